// File: rtl/otter_iobus_timer.sv
// Memory-mapped down-counting timer on the OTTER IOBUS: one-shot or auto-reload,
// programmable prescaler, level interrupt on expiry.
module otter_iobus_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0300,
  parameter int          PRESCALE_W = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_LOAD     = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  logic                  ctrl_en;
  logic                  ctrl_auto;
  logic                  ctrl_ie;
  logic [31:0]           load_reg;
  logic [31:0]           count_reg;
  logic                  exp_reg;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic [PRESCALE_W-1:0] pre_cnt;

  logic                  hit;
  logic [2:0]            offset;
  logic                  wr_hit;
  logic                  wr_ctrl;
  logic                  wr_load;
  logic                  wr_count;
  logic                  wr_status;
  logic                  wr_prescale;
  logic                  tick;
  logic                  expire;
  logic                  en_next;
  logic [PRESCALE_W-1:0] pre_next;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^IOBUS_ADDR[1:0];

  assign hit         = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign offset      = IOBUS_ADDR[4:2];
  assign wr_hit      = IOBUS_WR && hit;
  assign wr_ctrl     = wr_hit && (offset == OFF_CTRL);
  assign wr_load     = wr_hit && (offset == OFF_LOAD);
  assign wr_count    = wr_hit && (offset == OFF_COUNT);
  assign wr_status   = wr_hit && (offset == OFF_STATUS);
  assign wr_prescale = wr_hit && (offset == OFF_PRESCALE);

  assign tick   = ctrl_en && (pre_cnt == prescale_reg);
  // A software COUNT write on a tick cycle suppresses both decrement and expiry.
  assign expire = tick && (count_reg == 32'd0) && !wr_count;

  always_comb begin
    en_next = ctrl_en;
    if (wr_ctrl) begin
      en_next = IOBUS_OUT[0];
    end else if (expire && !ctrl_auto) begin
      en_next = 1'b0;
    end
  end

  // Prescaler sits at 0 while disabled and restarts on a 0->1 EN write.
  always_comb begin
    pre_next = pre_cnt;
    if (!en_next) begin
      pre_next = '0;
    end else if (wr_ctrl && !ctrl_en) begin
      pre_next = '0;
    end else if (tick) begin
      pre_next = '0;
    end else begin
      pre_next = pre_cnt + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_en      <= 1'b0;
      ctrl_auto    <= 1'b0;
      ctrl_ie      <= 1'b0;
      load_reg     <= 32'd0;
      count_reg    <= 32'd0;
      exp_reg      <= 1'b0;
      prescale_reg <= '0;
      pre_cnt      <= '0;
    end else begin
      ctrl_en <= en_next;
      pre_cnt <= pre_next;

      if (wr_ctrl) begin
        ctrl_auto <= IOBUS_OUT[1];
        ctrl_ie   <= IOBUS_OUT[2];
      end

      if (wr_load) begin
        load_reg <= IOBUS_OUT;
      end

      if (wr_prescale) begin
        prescale_reg <= IOBUS_OUT[PRESCALE_W-1:0];
      end

      // load_reg here is the pre-edge value, so a coincident LOAD write applies next reload.
      if (wr_count) begin
        count_reg <= IOBUS_OUT;
      end else if (tick) begin
        if (count_reg != 32'd0) begin
          count_reg <= count_reg - 32'd1;
        end else if (ctrl_auto) begin
          count_reg <= load_reg;
        end
      end

      if (expire) begin
        exp_reg <= 1'b1;
      end else if (wr_status && IOBUS_OUT[0]) begin
        exp_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    IOBUS_IN = 32'd0;
    if (hit) begin
      case (offset)
        OFF_CTRL:     IOBUS_IN = {29'd0, ctrl_ie, ctrl_auto, ctrl_en};
        OFF_LOAD:     IOBUS_IN = load_reg;
        OFF_COUNT:    IOBUS_IN = count_reg;
        OFF_STATUS:   IOBUS_IN = {31'd0, exp_reg};
        OFF_PRESCALE: IOBUS_IN = 32'(prescale_reg);
        default:      IOBUS_IN = 32'd0;
      endcase
    end
  end

  assign INTR = exp_reg && ctrl_ie;

endmodule
